// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM load sequencer and its region decoder.
package rom_load_pkg;

  // Sequencer states; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  // One-hot ROM region select: [0] program, [1] character, [2] sprite.
  typedef logic [2:0] region_t;

  localparam region_t REG_NONE = 3'b000;
  localparam region_t REG_PROG = 3'b001;
  localparam region_t REG_CHAR = 3'b010;
  localparam region_t REG_SPR  = 3'b100;

  localparam logic [7:0] ROM_IDX_DEF = 8'd0;
  localparam logic [7:0] DIP_IDX_DEF = 8'd254;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational ROM region decoder: download byte address -> one-hot region,
// region-relative address and out-of-range flag. Regions are packed back to
// back starting at address 0.
module rom_region_decode
  import rom_load_pkg::*;
#(
  parameter int unsigned PROG_SIZE = 12288,
  parameter int unsigned CHAR_SIZE = 2048,
  parameter int unsigned SPR_SIZE  = 2048
) (
  input  logic [24:0] addr,
  output region_t     region,
  output logic [13:0] rel_addr,
  output logic        out_of_range
);

  localparam logic [24:0] CHAR_BASE = 25'(PROG_SIZE);
  localparam logic [24:0] SPR_BASE  = 25'(PROG_SIZE + CHAR_SIZE);
  localparam logic [24:0] ROM_END   = 25'(PROG_SIZE + CHAR_SIZE + SPR_SIZE);

  logic [24:0] offset;

  // Pick the region and subtract its base; upper offset bits are dropped.
  always_comb begin
    region       = REG_NONE;
    offset       = addr;
    out_of_range = 1'b0;
    if (addr < CHAR_BASE) begin
      region = REG_PROG;
    end else if (addr < SPR_BASE) begin
      region = REG_CHAR;
      offset = addr - CHAR_BASE;
    end else if (addr < ROM_END) begin
      region = REG_SPR;
      offset = addr - SPR_BASE;
    end else begin
      out_of_range = 1'b1;
    end
  end

  assign rel_addr = offset[13:0];

endmodule

// File: rtl/rom_load_sequencer.sv
// ROM download router, DIP-switch capture and core reset sequencer.
// Optional build macro ROMLOAD_CHECKSUM_EN adds rom_sum/sum_ok and gates
// the HOLD->RUN exit on the image checksum matching EXP_SUM.
//
// state | meaning
// BOOT  | power-up, no ROM image yet, core held in reset
// LOAD  | ROM download in progress, bytes routed to regions
// HOLD  | settle period after a load or user reset
// RUN   | core released from reset
module rom_load_sequencer
  import rom_load_pkg::*;
#(
  parameter int unsigned PROG_SIZE   = 12288,
  parameter int unsigned CHAR_SIZE   = 2048,
  parameter int unsigned SPR_SIZE    = 2048,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter logic [7:0]  ROM_IDX     = ROM_IDX_DEF,
  parameter logic [7:0]  DIP_IDX     = DIP_IDX_DEF
`ifdef ROMLOAD_CHECKSUM_EN
  ,
  parameter logic [15:0] EXP_SUM     = 16'h0000
`endif
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        dn_ld,
  input  logic [7:0]  dn_index,
  input  logic        dn_wr,
  input  logic [24:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        user_reset,
  output logic [13:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [2:0]  rom_we,
  output logic [63:0] dip_sw,
  output logic        core_reset,
  output logic        load_err,
  output logic [1:0]  state_o
`ifdef ROMLOAD_CHECKSUM_EN
  ,
  output logic [15:0] rom_sum,
  output logic        sum_ok
`endif
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ld_prev_q, ld_prev_d;
  region_t           rom_we_q, rom_we_d;
  logic [13:0]       rom_addr_q, rom_addr_d;
  logic [7:0]        rom_data_q, rom_data_d;
  logic [63:0]       dip_q, dip_d;
  logic              err_q, err_d;
  logic [15:0]       sum_q, sum_d;

  region_t           dec_region;
  logic [13:0]       dec_rel;
  logic              dec_oor;
  logic              rom_start, ld_fall, rom_wr, dip_wr, hold_release;

  rom_region_decode #(
    .PROG_SIZE(PROG_SIZE),
    .CHAR_SIZE(CHAR_SIZE),
    .SPR_SIZE (SPR_SIZE)
  ) u_decode (
    .addr        (dn_addr),
    .region      (dec_region),
    .rel_addr    (dec_rel),
    .out_of_range(dec_oor)
  );

  assign rom_start = dn_ld & ~ld_prev_q & (dn_index == ROM_IDX);
  assign ld_fall   = ~dn_ld & ld_prev_q;
  assign rom_wr    = dn_wr & (dn_index == ROM_IDX) & (state_q == ST_LOAD);
  assign dip_wr    = dn_wr & (dn_index == DIP_IDX) & (dn_addr[24:3] == 22'd0);

`ifdef ROMLOAD_CHECKSUM_EN
  // A bad image parks the sequencer in HOLD so the core never runs on it.
  assign hold_release = (sum_q == EXP_SUM);
  assign rom_sum      = sum_q;
  assign sum_ok       = ((state_q == ST_HOLD) || (state_q == ST_RUN)) && (sum_q == EXP_SUM);
`else
  assign hold_release = 1'b1;
`endif

  // Next-state, hold counter, ROM write path, checksum and DIP bank.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_prev_d  = dn_ld;
    rom_we_d   = REG_NONE;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    dip_d      = dip_q;
    err_d      = err_q;
    sum_d      = sum_q;

    if (rom_wr) begin
      if (dec_oor) begin
        err_d = 1'b1;
      end else begin
        rom_we_d   = dec_region;
        rom_addr_d = dec_rel;
        rom_data_d = dn_data;
        sum_d      = sum_q + {8'd0, dn_data};
      end
    end

    if (dip_wr) begin
      dip_d[{dn_addr[2:0], 3'b000} +: 8] = dn_data;
    end

    unique case (state_q)
      ST_BOOT: begin
        if (rom_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (ld_fall) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (rom_start) begin
          state_d = ST_LOAD;
        end else if (user_reset) begin
          cnt_d = HOLD_LOAD;
        end else if (cnt_q == '0) begin
          if (hold_release) state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (rom_start) begin
          state_d = ST_LOAD;
        end else if (user_reset) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // A fresh load starts with a clean error flag and checksum.
    if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
      err_d = 1'b0;
      sum_d = 16'd0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_BOOT;
      cnt_q      <= '0;
      ld_prev_q  <= 1'b0;
      rom_we_q   <= REG_NONE;
      rom_addr_q <= 14'd0;
      rom_data_q <= 8'd0;
      dip_q      <= 64'd0;
      err_q      <= 1'b0;
      sum_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_prev_q  <= ld_prev_d;
      rom_we_q   <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      dip_q      <= dip_d;
      err_q      <= err_d;
      sum_q      <= sum_d;
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign dip_sw     = dip_q;
  assign load_err   = err_q;
  assign core_reset = (state_q != ST_RUN);
  assign state_o    = state_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Self-checking bench for rom_load_sequencer: a cycle-level behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_rom_load_sequencer;

  localparam int HOLD = 1024;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        dn_ld, dn_wr, user_reset;
  logic [7:0]  dn_index, dn_data;
  logic [24:0] dn_addr;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data;
  logic [2:0]  rom_we;
  logic [63:0] dip_sw;
  logic        core_reset, load_err;
  logic [1:0]  state_o;
`ifdef ROMLOAD_CHECKSUM_EN
  logic [15:0] rom_sum;
  logic        sum_ok;
`endif

  always #5 CLK = ~CLK;

  rom_load_sequencer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .dn_ld     (dn_ld),
    .dn_index  (dn_index),
    .dn_wr     (dn_wr),
    .dn_addr   (dn_addr),
    .dn_data   (dn_data),
    .user_reset(user_reset),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_we    (rom_we),
    .dip_sw    (dip_sw),
    .core_reset(core_reset),
    .load_err  (load_err),
    .state_o   (state_o)
`ifdef ROMLOAD_CHECKSUM_EN
    ,
    .rom_sum   (rom_sum),
    .sum_ok    (sum_ok)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: phase 0 boot, 1 loading, 2 holding, 3 running;
  // m_left counts the reset cycles still owed while holding.
  int          m_phase, m_left;
  bit          m_prev, m_err;
  logic [2:0]  m_we;
  logic [13:0] m_addr;
  logic [7:0]  m_data;
  logic [7:0]  m_dip [8];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_phase = 0; m_left = 0; m_prev = 0; m_err = 0;
      m_we = 0; m_addr = 0; m_data = 0;
      for (int i = 0; i < 8; i++) m_dip[i] = 8'h00;
    end else begin
      bit start, fall;
      int a, r;
      start = dn_ld && !m_prev && (dn_index == 8'd0);
      fall  = !dn_ld && m_prev;
      m_we  = 3'b000;
      if (m_phase == 1 && dn_wr && dn_index == 8'd0) begin
        a = int'(dn_addr);
        if (a < 12288)      begin m_we = 3'b001; r = a; end
        else if (a < 14336) begin m_we = 3'b010; r = a - 12288; end
        else if (a < 16384) begin m_we = 3'b100; r = a - 14336; end
        else begin m_err = 1; r = 0; end
        if (m_we != 0) begin m_addr = r[13:0]; m_data = dn_data; end
      end
      if (dn_wr && dn_index == 8'd254 && dn_addr < 25'd8) m_dip[dn_addr[2:0]] = dn_data;
      if (start && m_phase != 1) begin
        m_phase = 1; m_err = 0;
      end else if (m_phase == 1) begin
        if (fall) begin m_phase = 2; m_left = HOLD; end
      end else if (m_phase == 2) begin
        if (user_reset) m_left = HOLD;
        else if (m_left == 1) m_phase = 3;
        else m_left--;
      end else if (m_phase == 3) begin
        if (user_reset) begin m_phase = 2; m_left = HOLD; end
      end
      m_prev = dn_ld;
    end
  end

  int n_prog = 0, n_char = 0, n_spr = 0;

  // Every cycle out of reset: DUT outputs against the model.
  always @(negedge CLK) begin
    if (!RESET) begin
      logic [63:0] dip_exp;
      for (int i = 0; i < 8; i++) dip_exp[i*8 +: 8] = m_dip[i];
      chk("state_o", 64'(state_o), 64'(m_phase));
      chk("core_reset", 64'(core_reset), 64'(m_phase != 3));
      chk("rom_we", 64'(rom_we), 64'(m_we));
      chk("rom_addr", 64'(rom_addr), 64'(m_addr));
      chk("rom_data", 64'(rom_data), 64'(m_data));
      chk("load_err", 64'(load_err), 64'(m_err));
      chk("dip_sw", dip_sw, dip_exp);
      if (rom_we[0]) n_prog++;
      if (rom_we[1]) n_char++;
      if (rom_we[2]) n_spr++;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  // Number of sampled cycles core_reset stays high from now (bounded).
  task automatic count_high(output int n);
    n = 0;
    while (core_reset === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n, p0, c0, s0;
    RESET = 1; dn_ld = 0; dn_wr = 0; dn_index = 0; dn_addr = 0; dn_data = 0; user_reset = 0;
    repeat (3) tick();
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_rom_we", 64'(rom_we), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_rom_data", 64'(rom_data), 64'd0);
    chk("rst_dip_sw", dip_sw, 64'd0);
    chk("rst_load_err", 64'(load_err), 64'd0);
    RESET = 0;

    repeat (5000) tick();
    chk("boot_state", 64'(state_o), 64'd0);
    chk("boot_core_reset", 64'(core_reset), 64'd1);
    chk("boot_pulses", 64'(n_prog + n_char + n_spr), 64'd0);

    // Full image, back-to-back bytes; last byte coincides with dn_ld falling.
    p0 = n_prog; c0 = n_char; s0 = n_spr;
    dn_index = 8'd0; dn_ld = 1; tick();
    for (int a = 0; a < 16384; a++) begin
      dn_wr = 1; dn_addr = 25'(a); dn_data = a[7:0];
      if (a == 16383) dn_ld = 0;
      tick();
      if (a == 16'h3000) begin
        chk("b3000_we", 64'(rom_we), 64'b010);
        chk("b3000_addr", 64'(rom_addr), 64'd0);
        chk("b3000_data", 64'(rom_data), 64'd0);
      end
    end
    dn_wr = 0;
    count_high(n);
    chk("prog_pulses", 64'(n_prog - p0), 64'd12288);
    chk("char_pulses", 64'(n_char - c0), 64'd2048);
    chk("spr_pulses", 64'(n_spr - s0), 64'd2048);
    chk("load_hold_len", 64'(n), 64'(HOLD));
    chk("load_err_clean", 64'(load_err), 64'd0);
    chk("run_state", 64'(state_o), 64'd3);

    // One-cycle user reset pulse.
    chk("pre_pulse_core_reset", 64'(core_reset), 64'd0);
    user_reset = 1; tick();
    chk("pulse_core_reset_next", 64'(core_reset), 64'd1);
    user_reset = 0;
    count_high(n);
    chk("pulse_hold_len", 64'(n), 64'(HOLD));

    // Long user reset.
    user_reset = 1;
    repeat (3000) tick();
    chk("long_ur_core_reset", 64'(core_reset), 64'd1);
    user_reset = 0;
    count_high(n);
    chk("long_ur_hold_len", 64'(n), 64'(HOLD));

    // Out-of-range byte, then a fresh load clears the flag.
    dn_ld = 1; tick();
    dn_wr = 1; dn_addr = 25'h4000; dn_data = 8'h77; tick();
    dn_wr = 0;
    chk("oor_rom_we", 64'(rom_we), 64'd0);
    chk("oor_load_err", 64'(load_err), 64'd1);
    dn_ld = 0; tick();
    count_high(n);
    chk("oor_err_sticky", 64'(load_err), 64'd1);
    dn_ld = 1; tick(); tick();
    chk("reload_err_clear", 64'(load_err), 64'd0);
    dn_wr = 1; dn_addr = 25'h37FF; dn_data = 8'h5A; tick();
    chk("char_last_we", 64'(rom_we), 64'b010);
    chk("char_last_addr", 64'(rom_addr), 64'h7FF);
    dn_addr = 25'h3800; dn_data = 8'hC3; tick();
    chk("spr_first_we", 64'(rom_we), 64'b100);
    chk("spr_first_addr", 64'(rom_addr), 64'd0);
    dn_wr = 0; dn_ld = 0; tick();
    count_high(n);
    chk("reload_hold_len", 64'(n), 64'(HOLD));

    // DIP bytes while running; address 8 is outside the bank.
    dn_index = 8'd254; dn_ld = 1; tick();
    dn_wr = 1; dn_addr = 25'd0; dn_data = 8'hA5; tick();
    dn_addr = 25'd1; dn_data = 8'h3C; tick();
    dn_addr = 25'd8; dn_data = 8'hFF; tick();
    dn_wr = 0; dn_ld = 0; tick(); tick();
    chk("dip_low", 64'(dip_sw[15:0]), 64'h3CA5);
    chk("dip_high", 64'(dip_sw[63:16]), 64'd0);
    chk("dip_core_reset", 64'(core_reset), 64'd0);
    chk("dip_state", 64'(state_o), 64'd3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Sits between hps_io's ioctl download bus and the arcade core.
- Routes download bytes of index 0 into the program, character and sprite ROM regions, and captures index-254 bytes into the DIP-switch bank.
- Sequences core reset: holds the core in reset from power-up until the first ROM image is loaded, then for a fixed settle period after every download or user reset.
- Replaces ad-hoc reset ORing and the sw[] capture logic in the top level.

Parameters:
- PROG_SIZE, 12288: bytes in program ROM region; base 0x0000.
- CHAR_SIZE, 2048: bytes in character ROM region; base PROG_SIZE.
- SPR_SIZE, 2048: bytes in sprite ROM region; base PROG_SIZE+CHAR_SIZE.
- HOLD_CYCLES, 1024: CLK cycles core_reset stays high after load end or user reset; must be >= 1.
- ROM_IDX, 0: ioctl index carrying the ROM image.
- DIP_IDX, 254: ioctl index carrying DIP bytes.

Ports:
- CLK  in  1  system clock (clk_sys).
- RESET  in  1  asynchronous, active-high reset.
- dn_ld  in  1  download active (ioctl_download).
- dn_index  in  8  download index.
- dn_wr  in  1  one-cycle byte strobe.
- dn_addr  in  25  byte address within the download.
- dn_data  in  8  byte value.
- user_reset  in  1  OSD reset / button; level input.
- rom_addr  out  14  region-relative write address.
- rom_data  out  8  write data.
- rom_we  out  3  one-hot write enable: [0] prog, [1] char, [2] sprite.
- dip_sw  out  64  DIP bytes; byte n = bits 8n+7:8n.
- core_reset  out  1  reset to the core.
- load_err  out  1  sticky flag: a ROM byte fell outside all regions.
- state_o  out  2  current FSM state, for debug.

Behaviour:
Reset values:
- RESET asserted: state = BOOT, core_reset = 1, rom_we = 0, rom_addr = 0, rom_data = 0, dip_sw = 0, load_err = 0, hold counter = 0.

States (encoding 0..3):
- BOOT: core_reset = 1. Exit to LOAD on rising edge of dn_ld with dn_index == ROM_IDX. Stays here indefinitely if no ROM is ever loaded.
- LOAD: core_reset = 1.
  - On dn_wr, decode dn_addr against region bounds.
  - Registered one cycle later: rom_we one-hot pulse for one cycle, rom_addr = dn_addr minus region base (truncated to 14 bits), rom_data = dn_data.
  - If dn_addr >= PROG_SIZE+CHAR_SIZE+SPR_SIZE: no write, load_err set.
  - On falling edge of dn_ld: load counter with HOLD_CYCLES-1, go to HOLD.
- HOLD: core_reset = 1; counter decrements each cycle.
  - Counter == 0: go to RUN.
  - user_reset high reloads the counter and stays in HOLD.
  - A new ROM download start goes to LOAD.
- RUN: core_reset = 0.
  - user_reset high: go to HOLD with counter = HOLD_CYCLES-1; core_reset rises the next cycle.
  - ROM download start: go to LOAD.

Transition priority: ROM download start > user_reset > counter expiry.

DIP capture (independent of state; never touches core_reset):
- dn_wr with dn_index == DIP_IDX and dn_addr[24:3] == 0 writes dip_sw byte dn_addr[2:0] one cycle later.

Other rules:
- dn_wr with any other index, or any dn_wr outside LOAD: ignored, no rom_we.
- dn_wr coincident with the dn_ld fall: the byte is still written.
- load_err clears only on RESET or on entry to LOAD.
- Write latency is exactly 1 cycle. Back-to-back dn_wr on consecutive cycles must produce back-to-back rom_we pulses.

Optional Feature:
Macro: ROMLOAD_CHECKSUM_EN.
- Defined:
  - Adds output rom_sum [15:0]: modulo-2^16 sum of all in-range ROM bytes written during the most recent load; zeroed on LOAD entry, frozen in HOLD/RUN.
  - Adds parameter EXP_SUM (default 16'h0000) and output sum_ok [1 bit]: high in HOLD/RUN when rom_sum == EXP_SUM, low otherwise.
  - While sum_ok = 0, HOLD never exits to RUN.
- Undefined: no rom_sum, sum_ok or EXP_SUM; HOLD exits purely on the counter.

Decomposition:
- Package rom_load_pkg:
  - state enum (BOOT, LOAD, HOLD, RUN);
  - region-select typedef (one-hot 3 bits);
  - index constants ROM_IDX_DEF = 0, DIP_IDX_DEF = 254.
- One natural sub-module: rom_region_decode.
  - Combinational: address in -> region one-hot, relative address, out-of-range flag.
  - Reused by other arcade cores with different region maps.
- FSM, hold counter and DIP bank stay in the top module.

Test Plan:
- Reset, no download for 5000 cycles -> core_reset = 1, state_o = 0, rom_we = 0 throughout.
- ROM load of bytes 0x0000..0x3FFF, data = addr[7:0] -> exactly 12288 rom_we[0], 2048 rom_we[1], 2048 rom_we[2] pulses. Byte 0x3000 gives rom_we = 3'b010, rom_addr = 0, rom_data = 0x00. core_reset falls exactly HOLD_CYCLES cycles after dn_ld falls; load_err = 0.
- Write at dn_addr 0x4000 during LOAD -> no rom_we, load_err = 1. A second download then clears load_err.
- In RUN, pulse user_reset one cycle -> core_reset high the next cycle and for HOLD_CYCLES cycles, then low. Holding user_reset for 3000 cycles keeps core_reset high until HOLD_CYCLES after its release.
- DIP download index 254, bytes {0xA5, 0x3C} at addr 0,1 while in RUN -> dip_sw[7:0] = 0xA5, dip_sw[15:8] = 0x3C, core_reset stays 0. A byte at addr 8 is ignored.
- With ROMLOAD_CHECKSUM_EN, EXP_SUM mismatched -> state stays HOLD and core_reset = 1 indefinitely. With a matching EXP_SUM -> RUN as in the second scenario.
